segment_if_id_hs: RTL and testbench
===================================

# segment_if_id_hs

Parametrised IF/ID pipeline segment with a valid/ready handshake, a 2-entry elastic buffer, and a synchronous flush. It sits between the fetch stage (PC and instruction memory) and the decode stage. It presents the buffered PC plus pre-sliced instruction fields to decode. Fetch can keep issuing while decode stalls for one cycle without a combinational ready path back to fetch.

## Interface
Parameters:
- PC_W, 32, PC width.
- INSTR_W, 32, instruction width; must be ≥ 32 (field slices below are fixed bit positions).
- DEPTH, 2, buffer entries; legal values 1 or 2 (1 = plain register, no skid).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on the falling edge, matching the other pipeline segments.
- rst  in  1  synchronous active-high reset, sampled on the falling edge of clk.
- flush  in  1  discard all buffered entries (branch taken / exception).
- in_valid  in  1  fetch presents a valid PC/instruction pair.
- in_ready  out  1  segment will accept on this edge; registered, equals !full.
- pc_in  in  PC_W  fetch PC.
- instr_in  in  INSTR_W  fetched instruction.
- out_valid  out  1  head entry valid; registered, equals !empty.
- out_ready  in  1  decode consumes the head entry on this edge.
- pc  out  PC_W  head PC.
- instr  out  INSTR_W  head raw instruction.
- instr_type  out  2  instr[31:30].
- instr_opcode  out  5  instr[29:25].
- instr_27_0  out  28  instr[27:0].
- rs_a, rs_b, rd  out  5 each  instr[21:17], instr[19:15], instr[26:22].

## Operation
- Storage is a circular buffer of DEPTH entries {pc, instr}, with rd_ptr, wr_ptr and count (0..DEPTH).
- Accept = in_valid & in_ready & !flush.
- Pop = out_valid & out_ready & !flush.
- Simultaneous accept and pop: count unchanged, both pointers advance. When full, accept is blocked because in_ready is already 0; there is no same-edge pass-through.
- Pointer wrap: a pointer at DEPTH-1 advances to 0.
- Flush: next count = 0, pointers = 0, out_valid = 0, in_ready = 1. Flush has priority over accept and pop on the same edge, and the incoming instruction is dropped.
- When out_valid = 0 (bubble), all data outputs are driven as zero (NOP encoding 0x00000000, pc = 0). Buffer contents are masked, not cleared.
- Field outputs are pure slices of the head instr. They are valid exactly when out_valid = 1.
- Reset values: out_valid = 0, in_ready = 1, count = 0, pointers = 0, pc = 0, instr and all fields = 0, counters = 0.
- Reset mid-operation: any buffered entries are lost, with the same state as flush. rst has priority over flush.

## Timing
- Latency: an entry accepted on falling edge N appears at the outputs with out_valid = 1 after edge N, available to decode on edge N+1.
- Throughput: 1 per cycle while out_ready = 1.
- DEPTH = 2: in_ready falls only after two unconsumed accepts, so one cycle of decode stall loses no fetch slot.
- DEPTH = 1: in_ready = !out_valid, giving a 50% throughput bound under continuous flow. This is an accepted, documented limitation.
- in_ready and out_valid depend only on registered count, so there is no combinational input-to-output path on the control signals.

## Configuration
- SEGMENT_IF_ID_HS_PERF_EN defined: adds outputs stall_cnt (32-bit) and bubble_cnt (32-bit).
  - stall_cnt increments on edges with in_valid & !in_ready.
  - bubble_cnt increments on edges with !out_valid & out_ready.
  - Both wrap at 2^32, are cleared by rst, and are not cleared by flush.
- Not defined: the ports and logic are absent.

## Structure
- Shared pipeline package holds:
  - typedef if_id_entry_t {pc, instr};
  - field-position localparams (TYPE_MSB = 31, OPC_MSB = 29, RS_A_MSB = 21, RS_B_MSB = 19, RD_MSB = 26);
  - NOP_INSTR = 0.
- One sub-module, if_id_field_slicer: combinational, maps an instruction to type/opcode/27_0/rs_a/rs_b/rd. Decode reuses it.

## Test plan
- Reset, then 10 back-to-back accepts with pc 0x00, 0x04, … and out_ready = 1 -> each pc appears one edge later in order; out_valid continuous; in_ready stays 1.
- DEPTH = 2, out_ready = 0 for 2 cycles while in_valid = 1 -> count reaches 2; in_ready = 0 on the 3rd edge; after out_ready = 1, entries drain in order with none lost or duplicated.
- Full buffer, flush = 1 with in_valid = 1 (pc 0x40) -> next edge out_valid = 0, outputs all zero, in_ready = 1, pc 0x40 never appears.
- Instruction 0xB2A4C3E5 accepted -> instr_type = 2, instr_opcode = 0x19, rs_a = 0x12, rs_b = 0x09, rd = 0x0A, instr_27_0 = 0x2A4C3E5.
- rst asserted with 2 entries buffered, together with flush -> all outputs at reset values; with PERF_EN defined, stall_cnt = bubble_cnt = 0.
- PERF_EN defined: 3 edges with in_valid & !in_ready, then 4 edges with empty & out_ready -> stall_cnt = 3, bubble_cnt = 4.

Source files
------------

// File: rtl/segment_if_id_hs_pkg.sv
// Shared IF/ID pipeline definitions: the buffered entry type, instruction field positions and the
// NOP encoding. Decode reuses these through the field slicer.
package segment_if_id_hs_pkg;

    localparam int unsigned IF_ID_PC_W    = 32;
    localparam int unsigned IF_ID_INSTR_W = 32;

    typedef struct packed {
        logic [IF_ID_PC_W-1:0]    pc;
        logic [IF_ID_INSTR_W-1:0] instr;
    } if_id_entry_t;

    localparam int unsigned TYPE_MSB = 31;
    localparam int unsigned OPC_MSB  = 29;
    localparam int unsigned RS_A_MSB = 21;
    localparam int unsigned RS_B_MSB = 19;
    localparam int unsigned RD_MSB   = 26;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/segment_if_id_hs_field_slicer.sv
// Combinational instruction field slicer. Pure bit selects, so a zero instruction yields zero
// fields.
module if_id_field_slicer
    import segment_if_id_hs_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [1:0]  o_type,
    output logic [4:0]  o_opcode,
    output logic [27:0] o_27_0,
    output logic [4:0]  o_rs_a,
    output logic [4:0]  o_rs_b,
    output logic [4:0]  o_rd
);

    assign o_type   = i_instr[TYPE_MSB -: 2];
    assign o_opcode = i_instr[OPC_MSB -: 5];
    assign o_27_0   = i_instr[27:0];
    assign o_rs_a   = i_instr[RS_A_MSB -: 5];
    assign o_rs_b   = i_instr[RS_B_MSB -: 5];
    assign o_rd     = i_instr[RD_MSB -: 5];

endmodule

// File: rtl/segment_if_id_hs.sv
// IF/ID pipeline segment: DEPTH-entry elastic buffer with valid/ready handshake and flush.
// Define SEGMENT_IF_ID_HS_PERF_EN to add the stall_cnt / bubble_cnt performance counters.
module segment_if_id_hs
    import segment_if_id_hs_pkg::*;
#(
    parameter int unsigned PC_W    = IF_ID_PC_W,
    parameter int unsigned INSTR_W = IF_ID_INSTR_W,
    parameter int unsigned DEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    pc_in,
    input  logic [INSTR_W-1:0] instr_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] instr,
    output logic [1:0]         instr_type,
    output logic [4:0]         instr_opcode,
    output logic [27:0]        instr_27_0,
    output logic [4:0]         rs_a,
    output logic [4:0]         rs_b,
    output logic [4:0]         rd
`ifdef SEGMENT_IF_ID_HS_PERF_EN
    ,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        bubble_cnt
`endif
);

    if (INSTR_W < 32) begin : g_bad_instr_w
        $error("segment_if_id_hs: INSTR_W must be at least 32");
    end

    localparam logic [1:0] FULL_CNT = 2'(DEPTH);

    logic [1:0]         r_count, w_count_d;
    logic               r_rd_ptr, r_wr_ptr, w_rd_ptr_d, w_wr_ptr_d;
    logic [PC_W-1:0]    r_pc_mem    [DEPTH];
    logic [INSTR_W-1:0] r_instr_mem [DEPTH];
    logic               w_accept, w_pop;

    // Handshake outputs come straight from the registered count.
    assign in_ready  = (r_count != FULL_CNT);
    assign out_valid = (r_count != 2'd0);
    assign w_accept  = in_valid & in_ready & ~flush;
    assign w_pop     = out_valid & out_ready & ~flush;

    function automatic logic next_ptr(input logic p);
        return (32'(p) == DEPTH - 1) ? 1'b0 : ~p;
    endfunction

    always_comb begin
        w_count_d  = r_count;
        w_rd_ptr_d = r_rd_ptr;
        w_wr_ptr_d = r_wr_ptr;
        if (flush) begin
            w_count_d  = 2'd0;
            w_rd_ptr_d = 1'b0;
            w_wr_ptr_d = 1'b0;
        end else begin
            if (w_accept) w_wr_ptr_d = next_ptr(r_wr_ptr);
            if (w_pop)    w_rd_ptr_d = next_ptr(r_rd_ptr);
            if (w_accept && !w_pop) w_count_d = r_count + 2'd1;
            if (w_pop && !w_accept) w_count_d = r_count - 2'd1;
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            r_count  <= 2'd0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
        end else begin
            r_count  <= w_count_d;
            r_rd_ptr <= w_rd_ptr_d;
            r_wr_ptr <= w_wr_ptr_d;
        end
    end

    // Payload is never cleared; stale entries are hidden by the output mask below.
    always_ff @(negedge clk) begin
        if (w_accept) begin
            r_pc_mem[r_wr_ptr]    <= pc_in;
            r_instr_mem[r_wr_ptr] <= instr_in;
        end
    end

    assign pc    = out_valid ? r_pc_mem[r_rd_ptr] : '0;
    assign instr = out_valid ? r_instr_mem[r_rd_ptr] : INSTR_W'(NOP_INSTR);

    if_id_field_slicer u_slicer (
        .i_instr  (instr[31:0]),
        .o_type   (instr_type),
        .o_opcode (instr_opcode),
        .o_27_0   (instr_27_0),
        .o_rs_a   (rs_a),
        .o_rs_b   (rs_b),
        .o_rd     (rd)
    );

`ifdef SEGMENT_IF_ID_HS_PERF_EN
    logic [31:0] r_stall_cnt, r_bubble_cnt;

    // Counters survive flush; only rst clears them.
    always_ff @(negedge clk) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (in_valid && !in_ready)   r_stall_cnt  <= r_stall_cnt + 32'd1;
            if (!out_valid && out_ready) r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_segment_if_id_hs.sv
// Randomised scoreboard bench for segment_if_id_hs: accepted entries are queued as expected
// outputs and a monitor checks the head, handshake and fields before every falling edge.
module tb_segment_if_id_hs;
    import segment_if_id_hs_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] pc_in = '0, instr_in = '0;
    logic        in_ready, out_valid;
    logic [31:0] pc, instr;
    logic [1:0]  instr_type;
    logic [4:0]  instr_opcode, rs_a, rs_b, rd;
    logic [27:0] instr_27_0;
`ifdef SEGMENT_IF_ID_HS_PERF_EN
    logic [31:0] stall_cnt, bubble_cnt;
    logic [31:0] m_stall = '0, m_bubble = '0;
`endif

    segment_if_id_hs #(.PC_W(32), .INSTR_W(32), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .pc_in        (pc_in),
        .instr_in     (instr_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .pc           (pc),
        .instr        (instr),
        .instr_type   (instr_type),
        .instr_opcode (instr_opcode),
        .instr_27_0   (instr_27_0),
        .rs_a         (rs_a),
        .rs_b         (rs_b),
        .rd           (rd)
`ifdef SEGMENT_IF_ID_HS_PERF_EN
        ,
        .stall_cnt    (stall_cnt),
        .bubble_cnt   (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    if_id_entry_t exp_q[$];
    logic         acc_now = 1'b0;
    logic         armed = 1'b0;
    int           vectors = 0;
    int           errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; the DUT samples them on the falling edge.
    task automatic drive(input logic v, input logic [31:0] p, input logic [31:0] ins,
                         input logic ordy, input logic fl, input logic rs);
        @(posedge clk);
        #1;
        in_valid  = v;
        pc_in     = p;
        instr_in  = ins;
        out_ready = ordy;
        flush     = fl;
        rst       = rs;
        acc_now   = v && !fl && !rs && (exp_q.size() < DEPTH);
        if (acc_now) exp_q.push_back('{pc: p, instr: ins});
    endtask

    // Monitor: expected state before the coming falling edge is the queue minus this cycle's push.
    initial begin
        int          cnt;
        logic        e_ov, e_ir;
        logic [31:0] e_pc, e_in;
        forever begin
            @(posedge clk);
            #4;
            cnt  = exp_q.size() - (acc_now ? 1 : 0);
            e_ov = cnt > 0;
            e_ir = cnt < DEPTH;
            if (armed) begin
                e_pc = e_ov ? exp_q[0].pc : 32'h0;
                e_in = e_ov ? exp_q[0].instr : 32'h0;
                check("handshake", {62'h0, out_valid, in_ready}, {62'h0, e_ov, e_ir});
                check("pc", {32'h0, pc}, {32'h0, e_pc});
                check("instr", {32'h0, instr}, {32'h0, e_in});
                check("fields", {14'h0, instr_type, instr_opcode, rs_a, rs_b, rd, instr_27_0},
                      {14'h0, 2'((e_in >> 30) & 3), 5'((e_in >> 25) & 31), 5'((e_in >> 17) & 31),
                       5'((e_in >> 15) & 31), 5'((e_in >> 22) & 31), 28'(e_in % (1 << 28))});
`ifdef SEGMENT_IF_ID_HS_PERF_EN
                check("stall_cnt", {32'h0, stall_cnt}, {32'h0, m_stall});
                check("bubble_cnt", {32'h0, bubble_cnt}, {32'h0, m_bubble});
`endif
            end
            if (rst) begin
                armed = 1'b1;
                exp_q.delete();
`ifdef SEGMENT_IF_ID_HS_PERF_EN
                m_stall  = '0;
                m_bubble = '0;
`endif
            end else if (armed) begin
`ifdef SEGMENT_IF_ID_HS_PERF_EN
                if (in_valid && !e_ir)   m_stall++;
                if (!e_ov && out_ready)  m_bubble++;
`endif
                if (flush) exp_q.delete();
                else if (e_ov && out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] r;
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        // Back-to-back stream with decode always ready.
        for (int i = 0; i < 10; i++) drive(1, 32'(i * 4), $urandom, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        // Decode stalls: buffer fills and in_ready drops, then drains in order.
        for (int i = 0; i < 4; i++) drive(1, 32'h100 + 32'(i * 4), $urandom, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, 0);
        // Full buffer flushed while fetch offers pc 0x40.
        drive(1, 32'h200, $urandom, 0, 0, 0);
        drive(1, 32'h204, $urandom, 0, 0, 0);
        drive(1, 32'h40, 32'hDEAD_BEEF, 0, 1, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, 0);
        // Field decode of a known instruction.
        drive(1, 32'h300, 32'hB2A4_C3E5, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        // Two buffered entries hit by rst and flush together, then counter exercise.
        drive(1, 32'h400, $urandom, 0, 0, 0);
        drive(1, 32'h404, $urandom, 0, 0, 0);
        drive(1, 32'h408, $urandom, 0, 1, 1);
        drive(1, 32'h500, $urandom, 0, 0, 0);
        drive(1, 32'h504, $urandom, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 32'h508, $urandom, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 0, 0);
        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            drive(r[0] | r[1], {$urandom_range(0, 1023), 2'b00}, $urandom, r[2] | r[3],
                  r[7:4] == 4'h0, r[13:8] == 6'h0);
        end
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 0, 0);
        @(posedge clk);
        #6;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
